// File: rtl/out_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_stream_fifo
// Description : Output stream FIFO between the spectrometer core and the pad
//               side. First-word-fall-through, with an optional packet mode
//               that only releases complete frames (or an oversize frame
//               once the FIFO is full).
// Revision    : 1.0 - initial release
// ============================================================================
module out_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_last,
    input  logic                     cfg_packet_mode,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              frames_done
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]     c_ONE     = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);

    // Storage: each entry holds {last, data}
    logic [DW:0]        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wptr;
    logic [c_AW-1:0]    r_rptr;
    logic [c_AW:0]      r_level;
    logic [c_AW:0]      r_last_cnt;   // number of stored entries carrying last
    logic               r_flush;      // oversize frame is being released
    logic               r_mode;       // 1 = packet mode
    logic [15:0]        r_frames;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_release;
    logic [DW:0]        w_head;
    logic               w_head_last;

    // Handshake and release decision; derived only from registered state so
    // neither out_ready reaches in_ready nor in_valid reaches out_valid.
    always_comb begin
        w_full      = (r_level == c_FULL);
        w_empty     = (r_level == '0);
        w_head      = r_mem[r_rptr];
        w_head_last = w_head[DW];
        w_release   = !r_mode || (r_last_cnt != '0) || w_full || r_flush;
        in_ready    = !w_full;
        out_valid   = !w_empty && w_release;
        out_data    = w_head[DW-1:0];
        out_last    = w_head_last;
        level       = r_level;
        frames_done = r_frames;
        w_push      = in_valid && !w_full;
        w_pop       = out_valid && out_ready;
    end

    // Entry storage write; contents need no reset because level gates reads
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_last, in_data};
        end
    end

    // Pointers, occupancy, frame bookkeeping, mode and flush control
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_last_cnt <= '0;
            r_flush    <= 1'b0;
            r_frames   <= '0;
            r_mode     <= cfg_packet_mode;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_ONE;
                2'b01:   r_level <= r_level - c_ONE;
                default: r_level <= r_level;
            endcase

            case ({w_push && in_last, w_pop && w_head_last})
                2'b10:   r_last_cnt <= r_last_cnt + c_ONE;
                2'b01:   r_last_cnt <= r_last_cnt - c_ONE;
                default: r_last_cnt <= r_last_cnt;
            endcase

            // A full FIFO with no complete frame can never make progress in
            // packet mode, so the oversize frame is released until its last
            if (r_mode && out_valid && w_full && (r_last_cnt == '0)) begin
                r_flush <= 1'b1;
            end else if (w_pop && w_head_last) begin
                r_flush <= 1'b0;
            end

            if (w_pop && w_head_last) begin
                r_frames <= r_frames + 16'd1;
            end

            // Mode only switches while the FIFO is empty and stays empty
            if (w_empty && !w_push) begin
                r_mode <= cfg_packet_mode;
            end
        end
    end

endmodule
`default_nettype wire
